// File: rtl/sample_frame_buffer.sv
// Stereo sample FIFO between the music player and the codec, with frame-request and prime/run control.
// Latency: a popped pair appears on out_left/out_right one cycle after frame_tick; req_frame is registered.
// Backpressure: a single outstanding frame request; pushes into a full FIFO are dropped and flagged.
module sample_frame_buffer #(
   parameter int SAMPLE_W    = 16,
   parameter int DEPTH       = 8,
   parameter int ADDR_W      = 3,
   parameter int PRIME_LEVEL = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                frame_tick,
   input  logic                in_valid,
   input  logic [SAMPLE_W-1:0] in_left,
   input  logic [SAMPLE_W-1:0] in_right,
   output logic                req_frame,
   output logic [SAMPLE_W-1:0] out_left,
   output logic [SAMPLE_W-1:0] out_right,
   output logic                out_update,
   output logic [ADDR_W:0]     level,
   output logic                running,
   output logic [15:0]         underrun_count,
   output logic                overflow
);

   localparam logic [ADDR_W:0] LVL_FULL  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LVL_PRIME = (ADDR_W+1)'(PRIME_LEVEL);

   typedef enum logic {PRIME = 1'b0, RUN = 1'b1} state_t;

   state_t                    state, state_nxt;
   logic [2*SAMPLE_W-1:0]     mem [DEPTH];
   logic [ADDR_W-1:0]         rd_ptr, wr_ptr;
   logic                      outstanding;
   logic                      full, empty;
   logic                      pop, push, drop;
   logic                      underrun, prime_tick;
   logic                      issue;
   logic [ADDR_W+1:0]         lvl_plus_pop;
   logic [2*SAMPLE_W-1:0]     head;

   assign full  = (level == LVL_FULL);
   assign empty = (level == '0);
   assign head  = mem[rd_ptr];

   // A pop in the same cycle makes room, so a push into a full FIFO is only dropped without one.
   assign push = in_valid && (!full || pop);
   assign drop = in_valid && full && !pop;

   // Request only when nothing is outstanding and this cycle's occupancy leaves headroom.
   assign lvl_plus_pop = {1'b0, level} + {{(ADDR_W+1){1'b0}}, pop};
   assign issue        = !outstanding && (lvl_plus_pop < {1'b0, LVL_FULL});

   assign running = (state == RUN);

   // Next-state and per-cycle pop/underrun decisions.
   always_comb begin
      state_nxt  = state;
      pop        = 1'b0;
      underrun   = 1'b0;
      prime_tick = 1'b0;
      case (state)
         PRIME: begin
            prime_tick = frame_tick;
            if (level >= LVL_PRIME) state_nxt = RUN;
         end
         RUN: begin
            if (frame_tick) begin
               if (!empty) begin
                  pop = 1'b1;
               end else begin
                  underrun  = 1'b1;
                  state_nxt = PRIME;
               end
            end
         end
         default: state_nxt = PRIME;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= PRIME;
      else       state <= state_nxt;
   end

   // Sample storage; contents are don't-care once the pointers are reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {in_left, in_right};
   end

   // Pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Frame request engine: one request in flight, cleared by the next incoming pair.
   always_ff @(posedge clk) begin
      if (reset) begin
         req_frame   <= 1'b0;
         outstanding <= 1'b0;
      end else begin
         req_frame <= issue;
         if (issue)         outstanding <= 1'b1;
         else if (in_valid) outstanding <= 1'b0;
      end
   end

   // Output pair register: zeros while priming, head pair on a pop, hold on underrun.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_left   <= '0;
         out_right  <= '0;
         out_update <= 1'b0;
      end else begin
         out_update <= 1'b0;
         if (prime_tick) begin
            out_left   <= '0;
            out_right  <= '0;
            out_update <= 1'b1;
         end else if (pop) begin
            out_left   <= head[2*SAMPLE_W-1:SAMPLE_W];
            out_right  <= head[SAMPLE_W-1:0];
            out_update <= 1'b1;
         end
      end
   end

   // Status: saturating underrun counter and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         underrun_count <= '0;
         overflow       <= 1'b0;
      end else begin
         if (underrun && underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
         if (drop) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sample_frame_buffer.sv
// Directed bench for sample_frame_buffer: vector table plus hand sequences for overflow, reset and the request loop.
// Inputs are driven and outputs sampled on the falling clock edge.
// The player model answers each req_frame three cycles later.
module tb_sample_frame_buffer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        frame_tick = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_left = '0;
   logic [15:0] in_right = '0;
   logic        req_frame;
   logic [15:0] out_left, out_right;
   logic        out_update;
   logic [3:0]  level;
   logic        running;
   logic [15:0] underrun_count;
   logic        overflow;

   int compared = 0;
   int mismatched = 0;

   sample_frame_buffer #(.SAMPLE_W(16), .DEPTH(8), .ADDR_W(3), .PRIME_LEVEL(4)) dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .in_valid(in_valid),
      .in_left(in_left), .in_right(in_right), .req_frame(req_frame),
      .out_left(out_left), .out_right(out_right), .out_update(out_update),
      .level(level), .running(running), .underrun_count(underrun_count),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ft;
      logic        iv;
      logic [15:0] val;
      logic [3:0]  lvl;
      logic        run;
      logic [15:0] ol;
      logic        upd;
      logic [15:0] und;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Right channel carries 0x8000 | n for pair n; zero stays zero.
   function automatic logic [15:0] rval(input logic [15:0] n);
      return (n == 16'd0) ? 16'd0 : (16'h8000 | n);
   endfunction

   task automatic drive(input logic ft, input logic iv, input logic [15:0] val);
      frame_tick = ft;
      in_valid   = iv;
      in_left    = val;
      in_right   = rval(val);
   endtask

   task automatic add(input logic ft, input logic iv, input logic [15:0] val, input logic [3:0] lvl,
                      input logic run, input logic [15:0] ol, input logic upd, input logic [15:0] und);
      vq.push_back('{ft: ft, iv: iv, val: val, lvl: lvl, run: run, ol: ol, upd: upd, und: und});
   endtask

   initial begin
      int due, iv_cyc, reqs, pushes, first_req, bad_gap, req_at_full;
      logic [15:0] e;

      //   ft iv val lvl run out upd und
      add(0, 0, 0,  0, 0, 0,  0, 0);   // idle after reset
      add(0, 1, 1,  1, 0, 0,  0, 0);
      add(0, 1, 2,  2, 0, 0,  0, 0);
      add(1, 0, 0,  2, 0, 0,  1, 0);   // tick while priming: zeros, no pop
      add(0, 1, 3,  3, 0, 0,  0, 0);
      add(0, 1, 4,  4, 0, 0,  0, 0);   // reaches prime level, still PRIME
      add(0, 0, 0,  4, 1, 0,  0, 0);   // RUN the cycle after
      add(1, 0, 0,  3, 1, 1,  1, 0);   // first pop
      add(1, 1, 5,  3, 1, 2,  1, 0);   // push+pop, level unchanged
      add(1, 0, 0,  2, 1, 3,  1, 0);
      add(1, 0, 0,  1, 1, 4,  1, 0);
      add(1, 0, 0,  0, 1, 5,  1, 0);
      add(1, 0, 0,  0, 0, 5,  0, 1);   // underrun: hold, count, back to PRIME
      add(1, 1, 6,  1, 0, 0,  1, 1);   // tick in PRIME again
      add(0, 1, 7,  2, 0, 0,  0, 1);
      add(0, 1, 8,  3, 0, 0,  0, 1);
      add(0, 1, 9,  4, 0, 0,  0, 1);
      add(0, 0, 0,  4, 1, 0,  0, 1);
      add(1, 0, 0,  3, 1, 6,  1, 1);
      add(1, 0, 0,  2, 1, 7,  1, 1);
      add(1, 0, 0,  1, 1, 8,  1, 1);
      add(1, 0, 0,  0, 1, 9,  1, 1);
      add(1, 1, 10, 1, 0, 9,  0, 2);   // push+pop when empty: underrun, pair stored

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_level", level, 0);
      chk("rst_running", running, 0);
      chk("rst_out_left", out_left, 0);
      chk("rst_out_right", out_right, 0);
      chk("rst_out_update", out_update, 0);
      chk("rst_underrun", underrun_count, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_req_frame", req_frame, 0);
      reset = 1'b0;

      // Table-driven vectors
      foreach (vq[i]) begin
         drive(vq[i].ft, vq[i].iv, vq[i].val);
         @(negedge clk);
         chk($sformatf("v%0d_level", i), level, vq[i].lvl);
         chk($sformatf("v%0d_running", i), running, vq[i].run);
         chk($sformatf("v%0d_out_left", i), out_left, vq[i].ol);
         chk($sformatf("v%0d_out_right", i), out_right, rval(vq[i].ol));
         chk($sformatf("v%0d_out_update", i), out_update, vq[i].upd);
         chk($sformatf("v%0d_underrun", i), underrun_count, vq[i].und);
         chk($sformatf("v%0d_overflow", i), overflow, 0);
      end

      // Fill to full, then a dropped push and a push alongside a pop
      for (int n = 11; n <= 17; n++) begin
         drive(0, 1, 16'(n));
         @(negedge clk);
      end
      chk("full_level", level, 8);
      chk("full_running", running, 1);
      drive(0, 1, 16'd99);
      @(negedge clk);
      chk("drop_level", level, 8);
      chk("drop_overflow", overflow, 1);
      drive(1, 1, 16'd100);
      @(negedge clk);
      chk("pushpop_full_level", level, 8);
      chk("pushpop_full_overflow", overflow, 1);
      chk("pushpop_full_left", out_left, 16'd10);
      chk("pushpop_full_right", out_right, 16'h800A);
      chk("pushpop_full_update", out_update, 1);
      for (int k = 0; k < 8; k++) begin
         drive(1, 0, 0);
         @(negedge clk);
         e = (k < 7) ? 16'(11 + k) : 16'd100;
         chk($sformatf("drain%0d_left", k), out_left, e);
         chk($sformatf("drain%0d_right", k), out_right, rval(e));
         chk($sformatf("drain%0d_level", k), level, 7 - k);
      end

      // Reset mid-operation with five entries held
      for (int n = 200; n < 205; n++) begin
         drive(0, 1, 16'(n));
         @(negedge clk);
      end
      drive(0, 0, 0);
      chk("pre_reset_level", level, 5);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_level", level, 0);
      chk("mid_rst_running", running, 0);
      chk("mid_rst_out_left", out_left, 0);
      chk("mid_rst_out_right", out_right, 0);
      chk("mid_rst_underrun", underrun_count, 0);
      chk("mid_rst_overflow", overflow, 0);
      chk("mid_rst_req_frame", req_frame, 0);
      reset = 1'b0;
      @(negedge clk);

      // Player answers each request three cycles later
      due = -1; iv_cyc = -100; reqs = 0; pushes = 0;
      first_req = -1; bad_gap = 0; req_at_full = 0;
      for (int cyc = 0; cyc < 80; cyc++) begin
         if (req_frame) begin
            reqs++;
            if (first_req < 0) first_req = cyc;
            if (cyc - iv_cyc < 2) bad_gap++;
            if (level == 4'd8) req_at_full++;
            due = cyc + 3;
         end
         if (cyc == due) begin
            pushes++;
            drive(0, 1, 16'(pushes));
            iv_cyc = cyc;
         end else begin
            drive(0, 0, 0);
         end
         @(negedge clk);
      end
      chk("player_first_req_cycle", first_req, 0);
      chk("player_req_count", reqs, 8);
      chk("player_push_count", pushes, 8);
      chk("player_req_gap_violations", bad_gap, 0);
      chk("player_req_while_full", req_at_full, 0);
      chk("player_level", level, 8);
      chk("player_running", running, 1);

      // First pop after priming from the player
      drive(1, 0, 0);
      @(negedge clk);
      chk("first_pop_left", out_left, 16'h0001);
      chk("first_pop_right", out_right, 16'h8001);
      chk("first_pop_update", out_update, 1);
      chk("first_pop_level", level, 7);
      drive(0, 0, 0);
      @(negedge clk);
      chk("idle_update", out_update, 0);
      chk("idle_hold_left", out_left, 16'h0001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/sample_frame_buffer.md
Name: sample_frame_buffer

Overview:
- Stereo sample FIFO between music_player (producer) and adau1761_codec (consumer), all in the clk_100 domain.
- Issues frame requests to the player to keep the FIFO topped up; the request drives music_player.new_frame.
- Pops one left/right pair per codec frame tick and presents it as a registered hphone_l/hphone_r source.
- Primes before playback and reports underrun and overflow so codec timing jitter no longer couples directly to player latency.

Parameters:
- SAMPLE_W, 16, bits per channel sample.
- DEPTH, 8, FIFO entries; power of two, minimum 4.
- ADDR_W, 3, log2(DEPTH).
- PRIME_LEVEL, 4, occupancy required before leaving PRIME; 1..DEPTH.

Ports:
- clk  in  1  system clock (clk_100).
- reset  in  1  synchronous, active-high.
- frame_tick  in  1  one-cycle pulse from the codec's new_sample; requests one output pair.
- in_valid  in  1  one-cycle pulse from the player's new_sample_generated.
- in_left  in  SAMPLE_W  left sample; valid with in_valid.
- in_right  in  SAMPLE_W  right sample; valid with in_valid.
- req_frame  out  1  one-cycle pulse to the player's new_frame input.
- out_left  out  SAMPLE_W  registered left sample to the codec.
- out_right  out  SAMPLE_W  registered right sample to the codec.
- out_update  out  1  pulses the cycle out_left/out_right change.
- level  out  ADDR_W+1  current FIFO occupancy, 0..DEPTH.
- running  out  1  1 in RUN state.
- underrun_count  out  16  saturating count of underruns.
- overflow  out  1  sticky; set when a push is dropped.

Behaviour:
- Reset values: every output is 0; FIFO empty; read and write pointers 0; outstanding flag 0; state PRIME.
- Storage: circular buffer of {left,right}; pointers wrap modulo DEPTH.
- Occupancy:
  - level = pushes accepted − pops.
  - full when level==DEPTH; empty when level==0.
- Push:
  - in_valid accepted when not full, or when a pop occurs in the same cycle.
  - Otherwise the pair is dropped and overflow is set to 1 (sticky until reset).
- Request engine:
  - Single outstanding request.
  - req_frame pulses when outstanding==0 and (level + pending pops this cycle) < DEPTH.
  - The pulse sets outstanding=1.
  - The next in_valid clears outstanding; a new req_frame may issue no earlier than the cycle after that clear.
  - in_valid with outstanding==0 is still pushed.
  - No timeout.
- State machine:
  - PRIME:
    - frame_tick does not pop; out_left/out_right are driven to 0 with out_update=1, one cycle after the tick.
    - No underrun is counted.
    - Go to RUN the cycle after level >= PRIME_LEVEL.
  - RUN, frame_tick with level>0:
    - Pop the head.
    - out_left/out_right take the head pair on the next cycle, with out_update=1 (latency 1).
  - RUN, frame_tick with level==0:
    - Underrun: outputs hold their last value and out_update=0.
    - underrun_count increments, saturating at 16'hFFFF.
    - Next state is PRIME.
- Simultaneous events:
  - Push+pop when empty in RUN: counts as an underrun; the pushed pair is stored, with no bypass.
  - Push+pop when full: both are performed and level is unchanged.
  - Push+pop otherwise: both are performed and level is unchanged.
- running = (state==RUN), registered.
- Reset mid-operation: all contents are discarded, the outstanding request is cancelled, and state returns to PRIME with all outputs 0 on the next cycle.
- Arithmetic: pointers ADDR_W bits with natural wrap; level ADDR_W+1 bits; no signed arithmetic; samples are passed through bit-exact.

Test Plan:
- Reset, then the player answers each req_frame after 3 cycles with pairs L=0x0001..,R=0x8001.. -> req_frame pulses are spaced ≥1 cycle after each in_valid; level climbs to 8 and no req_frame issues while level==8.
- Prime then drain: after level≥4, running=1; a frame_tick -> the next cycle has out_left=0x0001, out_right=0x8001, out_update=1, and level decrements by 1.
- frame_tick in PRIME (level=2) -> outputs 0, out_update=1, level stays 2, underrun_count stays 0.
- Player stalled in RUN: frame_tick with level 0 -> outputs hold their previous pair, underrun_count=1, running=0 the next cycle; refill to 4 -> running=1.
- Forced in_valid with level=8 and no frame_tick -> pair dropped, overflow=1, level=8. Same with a frame_tick in the same cycle -> pair stored, overflow unchanged, level=8.
- Reset asserted with level=5 and a request outstanding -> next cycle level=0, running=0, outputs 0, underrun_count=0; the first req_frame issues after reset deasserts.
